// File: rtl/sat_bin_readback.sv
// sat_bin_readback: reads the clause bin RAM then the var bin RAM at
// addresses 1..count through the sat_bin external port and streams the
// words out on a valid/ready interface with a 2-entry output buffer.
// Optional feature macro: SAT_BIN_READBACK_CHECKSUM_EN (XOR checksum of
// every transferred word on checksum_o; constant 0 when undefined).
module sat_bin_readback #(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int WIDTH_CLAUSES      = 16,
  parameter int WIDTH_VAR          = 12,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int ADDR_WIDTH_VAR     = 9,
  parameter int WIDTH_NB           = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [WIDTH_NB-1:0]           nb_i,
  output logic                          done_o,
  output logic                          apply_ex_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_o,
  input  logic [WIDTH_CLAUSES-1:0]      ram_dout_c_i,
  output logic [ADDR_WIDTH_VAR-1:0]     ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]          ram_dout_v_i,
  output logic [WIDTH_CLAUSES-1:0]      data_o,
  output logic                          tag_o,
  output logic                          last_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WIDTH_CLAUSES-1:0]      checksum_o
);

  localparam int AW = ADDR_WIDTH_CLAUSES;
  // buffer entry layout: {data, tag, last}
  localparam int EW = WIDTH_CLAUSES + 2;
  localparam int PW = WIDTH_NB + $clog2(NUM_CLAUSES_A_BIN + 1);
  localparam logic [PW-1:0] SLOTS     = PW'(NUM_CLAUSES_A_BIN);
  localparam logic [PW-1:0] MAX_COUNT = PW'((1 << AW) - 1);

  typedef enum logic [2:0] {IDLE, RD_C, RD_V, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] count_reg;
  logic [AW-1:0] issue_addr_reg;
  logic [AW-1:0] addr_c_reg, addr_v_reg;
  logic          inflight_reg, inflight_tag_reg, inflight_last_reg;
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    occ_reg;

  logic [PW-1:0] nb_prod;
  logic [AW-1:0] count_sat;
  logic          rd_phase, credit_ok, issue, last_issue;
  logic          xfer, push, pop_fifo, drained;
  logic [EW-1:0] in_word, head_fifo, head_word;
  logic [EW-1:0] entry_q [2];

  // Saturate the slot count so addresses never wrap past the RAM top.
  assign nb_prod   = PW'(nb_i) * SLOTS;
  assign count_sat = (nb_prod > MAX_COUNT) ? MAX_COUNT[AW-1:0] : nb_prod[AW-1:0];

  // A read may issue only if the buffer can still absorb it when it returns.
  assign rd_phase   = (state_reg == RD_C) || (state_reg == RD_V);
  assign credit_ok  = ({1'b0, occ_reg} + {2'b0, inflight_reg} + 3'd1) <= 3'd2;
  assign issue      = rd_phase && credit_ok;
  assign last_issue = issue && (issue_addr_reg == count_reg);

  // Address ports show the new address in the issue cycle, otherwise hold.
  assign ram_addr_c_o = (issue && state_reg == RD_C) ? issue_addr_reg : addr_c_reg;
  assign ram_addr_v_o = (issue && state_reg == RD_V) ? issue_addr_reg : addr_v_reg;

  // Returning RAM word; var words are zero-extended to the stream width.
  assign in_word = inflight_tag_reg ?
                   {WIDTH_CLAUSES'(ram_dout_v_i), 1'b1, inflight_last_reg} :
                   {ram_dout_c_i, 1'b0, inflight_last_reg};

  // The returning word is visible as the head when the buffer is empty, so
  // the stream runs gap-free with RAM latency 1.
  assign head_fifo = rd_ptr_reg ? entry_q[1] : entry_q[0];
  assign valid_o   = (occ_reg != 2'd0) || inflight_reg;
  assign head_word = (occ_reg != 2'd0) ? head_fifo : in_word;
  assign {data_o, tag_o, last_o} = valid_o ? head_word : '0;

  assign xfer     = valid_o && ready_i;
  assign pop_fifo = xfer && (occ_reg != 2'd0);
  assign push     = inflight_reg && !(xfer && occ_reg == 2'd0);
  // Nothing left once this cycle's transfer (if any) completes.
  assign drained  = (occ_reg == 2'd0 && !inflight_reg) ||
                    (({1'b0, occ_reg} + {2'b0, inflight_reg}) == 3'd1 && xfer);

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    done_o     = 1'b0;
    apply_ex_o = 1'b0;
    case (state_reg)
      IDLE:  if (start_i) state_next = (count_sat == '0) ? DONE : RD_C;
      RD_C: begin
        apply_ex_o = 1'b1;
        if (last_issue) state_next = RD_V;
      end
      RD_V: begin
        apply_ex_o = 1'b1;
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        apply_ex_o = 1'b1;
        if (drained) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Count latch, issue address counter and held address ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg      <= '0;
      issue_addr_reg <= '0;
      addr_c_reg     <= '0;
      addr_v_reg     <= '0;
    end else begin
      if (state_reg == IDLE && start_i) begin
        count_reg      <= count_sat;
        issue_addr_reg <= AW'(1);
      end else if (issue) begin
        issue_addr_reg <= last_issue ? AW'(1) : issue_addr_reg + AW'(1);
      end
      if (state_next == IDLE) begin
        addr_c_reg <= '0;
        addr_v_reg <= '0;
      end else begin
        addr_c_reg <= ram_addr_c_o;
        addr_v_reg <= ram_addr_v_o;
      end
    end
  end

  // Tracks the read whose data arrives from the RAM next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_reg      <= 1'b0;
      inflight_tag_reg  <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_tag_reg  <= (state_reg == RD_V);
      inflight_last_reg <= last_issue && (state_reg == RD_V);
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push)     wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_fifo) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop_fifo})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Buffer storage, one register per entry.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [EW-1:0] entry_reg;
    // Capture the returning word into the entry the write pointer selects.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               entry_reg <= '0;
      else if (push && wr_ptr_reg == 1'(gi))  entry_reg <= in_word;
    end
    assign entry_q[gi] = entry_reg;
  end

`ifdef SAT_BIN_READBACK_CHECKSUM_EN
  logic [WIDTH_CLAUSES-1:0] checksum_reg;
  // XOR of every transferred word since the last accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             checksum_reg <= '0;
    else if (state_reg == IDLE && start_i) checksum_reg <= '0;
    else if (xfer)                        checksum_reg <= checksum_reg ^ data_o;
  end
  assign checksum_o = checksum_reg;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_sat_bin_readback.sv
// Testbench for sat_bin_readback: RAM models, scoreboard queue filled by
// the stimulus thread, monitor popping on every stream handshake.
module tb_sat_bin_readback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] nb_i = '0;
  logic        done_o, apply_ex_o;
  logic [8:0]  ram_addr_c_o, ram_addr_v_o;
  logic [15:0] ram_dout_c_i = '0;
  logic [11:0] ram_dout_v_i = '0;
  logic [15:0] data_o, checksum_o;
  logic        tag_o, last_o, valid_o;
  logic        ready_i = 1'b1;

  logic [15:0] mem_c [512];
  logic [11:0] mem_v [512];

  logic [17:0] expq [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          rk = 0;
  logic        apply_seen = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [17:0] prev_word = '0;

  sat_bin_readback dut (
    .clk(clk), .rst(rst), .start_i(start_i), .nb_i(nb_i),
    .done_o(done_o), .apply_ex_o(apply_ex_o),
    .ram_addr_c_o(ram_addr_c_o), .ram_dout_c_i(ram_dout_c_i),
    .ram_addr_v_o(ram_addr_v_o), .ram_dout_v_i(ram_dout_v_i),
    .data_o(data_o), .tag_o(tag_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models with one cycle read latency.
  always @(posedge clk) begin
    ram_dout_c_i <= mem_c[ram_addr_c_o];
    ram_dout_v_i <= mem_v[ram_addr_v_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    logic [17:0] w;
    logic [17:0] e;
    w = {data_o, tag_o, last_o};
    if (apply_ex_o) apply_seen = 1'b1;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid", {31'd0, valid_o}, 32'd1);
        check("stall_word", {14'd0, w}, {14'd0, prev_word});
      end
      if (valid_o && ready_i) begin
        if (expq.size() == 0) begin
          check("unexpected_word", {31'd0, valid_o}, 32'd0);
        end else begin
          e = expq.pop_front();
          check("word", {14'd0, w}, {14'd0, e});
        end
        $display("xfer cyc=%0d data=%04h tag=%0d last=%0d", cyc, data_o, tag_o, last_o);
      end
      prev_valid = valid_o;
      prev_ready = ready_i;
      prev_word  = w;
    end
  end

  // Ready pattern: mode 0 always ready; mode 1 toggles with a 20-cycle stall.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        rk = 0;
        ready_i = 1'b1;
      end else begin
        ready_i = (rk >= 6 && rk < 26) ? 1'b0 : rk[0];
        rk++;
      end
    end
  end

  task automatic push_expected(input int n);
    logic [15:0] cw;
    logic [11:0] vw;
    for (int a = 1; a <= n; a++) begin
      cw = 16'(a * 257);
      expq.push_back({cw, 1'b0, 1'b0});
    end
    for (int a = 1; a <= n; a++) begin
      vw = 12'(16 + a);
      expq.push_back({4'h0, vw, 1'b1, (a == n)});
    end
  endtask

  // Pulses start_i for one cycle; t0 is the cycle in which it was high.
  task automatic do_start(input logic [15:0] nb, output int t0);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    nb_i    = nb;
    t0      = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},  {31'd0, done_o}, 32'd0);
    check({tag, "_apply"}, {31'd0, apply_ex_o}, 32'd0);
    check({tag, "_addr_c"}, {23'd0, ram_addr_c_o}, 32'd0);
    check({tag, "_addr_v"}, {23'd0, ram_addr_v_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_data"},  {16'd0, data_o}, 32'd0);
    check({tag, "_tag"},   {31'd0, tag_o}, 32'd0);
    check({tag, "_last"},  {31'd0, last_o}, 32'd0);
    check({tag, "_cksum"}, {16'd0, checksum_o}, 32'd0);
  endtask

  task automatic check_checksum16();
`ifdef SAT_BIN_READBACK_CHECKSUM_EN
    check("checksum_at_done", {16'd0, checksum_o}, 32'h0800);
`else
    check("checksum_zero", {16'd0, checksum_o}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int td;
    mem_c[0] = 16'hDEAD;
    mem_v[0] = 12'hBAD;
    for (int a = 1; a < 512; a++) begin
      mem_c[a] = 16'(a * 257);
      mem_v[a] = 12'(16 + a);
    end

    // Reset state
    #3;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Scenario 1: nb=1, always ready
    push_expected(8);
    do_start(16'd1, t0);
    @(negedge clk);
    check("s1_addr1_at_T1", {23'd0, ram_addr_c_o}, 32'd1);
    check("s1_apply_at_T1", {31'd0, apply_ex_o}, 32'd1);
    check("s1_valid_at_T1", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    check("s1_valid_at_T2", {31'd0, valid_o}, 32'd1);
    wait_done(100, td);
    check("s1_done_latency", td - t0, 32'd18);
    check_checksum16();
    check("s1_queue_empty", expq.size(), 32'd0);
    @(negedge clk);
    check("s1_idle_apply", {31'd0, apply_ex_o}, 32'd0);
    check("s1_idle_addr_c", {23'd0, ram_addr_c_o}, 32'd0);
    check("s1_idle_addr_v", {23'd0, ram_addr_v_o}, 32'd0);

    // Scenario 2: nb=0 -> immediate done, no words, no port ownership
    apply_seen = 1'b0;
    do_start(16'd0, t0);
    wait_done(20, td);
    check("s2_done_latency", td - t0, 32'd1);
    repeat (3) @(negedge clk);
    check("s2_apply_never", {31'd0, apply_seen}, 32'd0);
    check("s2_queue_empty", expq.size(), 32'd0);

    // Scenario 3: nb=2 with toggling ready and a long stall
    push_expected(16);
    ready_mode = 1;
    do_start(16'd2, t0);
    wait_done(300, td);
    ready_mode = 0;
    check("s3_queue_empty", expq.size(), 32'd0);
    check("s3_stretched", {31'd0, (td - t0) > 34}, 32'd1);

    // Scenario 4: saturated count 511
    push_expected(511);
    do_start(16'hFFFF, t0);
    wait_done(1200, td);
    check("s4_done_latency", td - t0, 32'd1024);
    check("s4_queue_empty", expq.size(), 32'd0);

    // Scenario 5: reset during the var phase, then a clean run
    push_expected(16);
    do_start(16'd2, t0);
    repeat (19) @(posedge clk);
    #2;
    check("s5_apply_before_rst", {31'd0, apply_ex_o}, 32'd1);
    check("s5_tag_before_rst", {31'd0, tag_o}, 32'd1);
    rst = 1'b0;
    expq.delete();
    #1;
    check_all_zero("s5_async_rst");
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_all_zero("s5_after_rst");
    push_expected(8);
    do_start(16'd1, t0);
    wait_done(100, td);
    check("s5_done_latency", td - t0, 32'd18);
    check_checksum16();
    check("s5_queue_empty", expq.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
